// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES-128 key schedule, one round key per round step.
// Holds rk0..rk10 on a flat bus for the downstream counter-mode cipher pipeline.
// Optional macro AES_KEY_EXPAND_SBOX_REG_EN: registers SubWord(RotWord(w3)),
// so each round takes two cycles (20-cycle expansion instead of 10).

// Combinational AES S-box: the high nibble selects a 16-byte row, and the low nibble picks the byte.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    logic [127:0] row;
    logic [6:0]   idx;

    // Row lookup, then byte select (byte 0 of a row sits in the MSBs)
    always_comb begin
        row = '0;
        case (a[7:4])
            4'h0: row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1: row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2: row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3: row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4: row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5: row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6: row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7: row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8: row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9: row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha: row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb: row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc: row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd: row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he: row = 128'he1f8981169d98e949b1e87e9ce5528df;
            4'hf: row = 128'h8ca1890dbfe6426841992d0fb054bb16;
            default: row = '0;
        endcase
        idx = {~a[3:0], 3'b000};
        s   = row[idx +: 8];
    end
endmodule

module aes_key_expand (
    input  logic          clk,
    input  logic          rst,
    input  logic [127:0]  key_in,
    input  logic          key_valid,
    output logic          key_ready,
    output logic [1407:0] round_keys,
    output logic          keys_valid,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t             state, state_nxt;
    logic [127:0]       w;          // working words {w0,w1,w2,w3}, w0 in the MSBs
    logic [10:0][127:0] rk;
    logic [7:0]         rcon;
    logic [3:0]         round_cnt;
    logic [31:0]        rot_w3, sub_rot, temp;
    logic [31:0]        w0n, w1n, w2n, w3n;
    logic [127:0]       w_nxt;
    logic [7:0]         rcon_nxt;
    logic               accept, step;

    assign round_keys = rk;
    assign accept     = key_valid && key_ready;

    // RotWord: rotate bytes left by one, then four parallel S-box lookups
    assign rot_w3 = {w[23:0], w[31:24]};

    genvar i;
    generate
        for (i = 0; i < 4; i++) begin : g_sbox
            aes_sbox u_sbox (.a(rot_w3[8*i +: 8]), .s(sub_rot[8*i +: 8]));
        end
    endgenerate

`ifdef AES_KEY_EXPAND_SBOX_REG_EN
    logic        phase;     // 0: cycle A (capture S-box), 1: cycle B (update w/rk)
    logic [31:0] sub_q;

    assign step = (state == EXPAND) && phase;
    assign temp = sub_q ^ {rcon, 24'h0};

    // S-box result register and two-cycle round phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= 1'b0;
            sub_q <= '0;
        end else if (accept) begin
            phase <= 1'b0;
        end else if (state == EXPAND) begin
            phase <= ~phase;
            if (!phase) sub_q <= sub_rot;
        end
    end
`else
    assign step = (state == EXPAND);
    assign temp = sub_rot ^ {rcon, 24'h0};
`endif

    // Round function: chained XOR of the four words, plus xtime for rcon
    always_comb begin
        w0n      = w[127:96] ^ temp;
        w1n      = w[95:64]  ^ w0n;
        w2n      = w[63:32]  ^ w1n;
        w3n      = w[31:0]   ^ w2n;
        w_nxt    = {w0n, w1n, w2n, w3n};
        rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; busy and key_ready depend only on the state
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        key_ready = 1'b1;
        case (state)
            IDLE:   if (key_valid) state_nxt = EXPAND;
            EXPAND: begin
                busy      = 1'b1;
                key_ready = 1'b0;
                if (step && round_cnt == 4'd10) state_nxt = DONE;
            end
            DONE:   if (key_valid) state_nxt = EXPAND;
            default: state_nxt = IDLE;
        endcase
    end

    // Key load and per-round update of working words, round keys, and rcon
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w          <= '0;
            rk         <= '0;
            rcon       <= 8'h01;
            round_cnt  <= 4'd0;
            keys_valid <= 1'b0;
        end else if (accept) begin
            w          <= key_in;
            rk[0]      <= key_in;
            rcon       <= 8'h01;
            round_cnt  <= 4'd1;
            keys_valid <= 1'b0;
        end else if (step) begin
            w             <= w_nxt;
            rk[round_cnt] <= w_nxt;
            rcon          <= rcon_nxt;
            if (round_cnt == 4'd10) keys_valid <= 1'b1;
            else                    round_cnt  <= round_cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed key-schedule vectors from FIPS-197 with latency,
// handshake, rekey, async reset and rcon checks.
`timescale 1ns/1ps
module tb_aes_key_expand;
`ifdef AES_KEY_EXPAND_SBOX_REG_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int LAT = 10 * STEP;

    localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1_RK2 = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KZ     = 128'h0;
    localparam logic [127:0] KZ_RK1 = 128'h62636363626363636263636362636363;
    localparam logic [127:0] KZ_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    logic          clk = 1'b0;
    logic          rst;
    logic [127:0]  key_in;
    logic          key_valid;
    logic          key_ready;
    logic [1407:0] round_keys;
    logic          keys_valid;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    int busy_len;
    logic [7:0]   rc9, rc10;
    logic [127:0] rk1_early;

    aes_key_expand dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .round_keys (round_keys),
        .keys_valid (keys_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rk(input int i);
        return round_keys[128*i +: 128];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a key for one edge (caller ensures key_ready is high)
    task automatic give_key(input logic [127:0] k);
        @(negedge clk);
        key_in    = k;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    // Wait for keys_valid with a bounded cycle count; -1 on timeout
    task automatic wait_done(output int cycles);
        int n;
        n = 0;
        busy_len = 1;   // the sample right after the accept edge was busy
        cycles = -1;
        for (int c = 1; c <= 4 * LAT; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (busy && keys_valid) overlap++;
            if (busy) busy_len++;
            if (n == STEP) rk1_early = rk(1);
            if (busy && dut.round_cnt == 4'd9)  rc9  = dut.rcon;
            if (busy && dut.round_cnt == 4'd10) rc10 = dut.rcon;
            if (keys_valid) begin
                cycles = n;
                break;
            end
        end
    endtask

    initial begin
        int cyc;
        int rises, highs, r1, r2;
        logic prev;

        rst = 1'b1;
        key_in = '0;
        key_valid = 1'b0;
        rc9 = '0;
        rc10 = '0;
        rk1_early = '0;
        #12;
        // reset state
        chk("rst_rk_zero", round_keys != '0, 0);
        chk("rst_keys_valid", keys_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_key_ready", key_ready, 1);
        chk("rst_rcon", dut.rcon, 8'h01);
        chk("rst_round", dut.round_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // FIPS-197 key
        give_key(K1);
        chk("k1_rk0", rk(0), K1);
        chk("k1_busy", busy, 1);
        chk("k1_ready_low", key_ready, 0);
        chk("k1_kv_low", keys_valid, 0);
        wait_done(cyc);
        chk("k1_latency", cyc, LAT);
        chk("k1_busy_len", busy_len, LAT);
        chk("k1_rk1_early", rk1_early, K1_RK1);
        chk("k1_rk1", rk(1), K1_RK1);
        chk("k1_rk2", rk(2), K1_RK2);
        chk("k1_rk10", rk(10), K1_R10);
        chk("rcon_r9", rc9, 8'h1b);
        chk("rcon_r10", rc10, 8'h36);
        chk("done_ready", key_ready, 1);
        chk("done_busy", busy, 0);

        // all-zero key from DONE
        give_key(KZ);
        chk("kz_kv_fall", keys_valid, 0);
        wait_done(cyc);
        chk("kz_latency", cyc, LAT);
        chk("kz_rk1", rk(1), KZ_RK1);
        chk("kz_rk10", rk(10), KZ_R10);

        // key pulsed while busy is ignored
        give_key(K1);
        repeat (3 * STEP) @(posedge clk);
        @(negedge clk);
        key_in = KZ;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        wait_done(cyc);
        chk("ign_done", keys_valid, 1);
        chk("ign_rk1", rk(1), K1_RK1);
        chk("ign_rk10", rk(10), K1_R10);
        give_key(KZ);
        chk("rekey_kv_fall", keys_valid, 0);
        chk("rekey_rk0", rk(0), KZ);
        wait_done(cyc);
        chk("rekey_latency", cyc, LAT);
        chk("rekey_rk1", rk(1), KZ_RK1);
        chk("rekey_rk10", rk(10), KZ_R10);

        // asynchronous reset in the middle of round 6
        give_key(K1);
        repeat (5 * STEP) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_rk_zero", round_keys != '0, 0);
        chk("arst_keys_valid", keys_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_key_ready", key_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        give_key(KZ);
        wait_done(cyc);
        chk("arst_latency", cyc, LAT);
        chk("arst_rk1", rk(1), KZ_RK1);
        chk("arst_rk10", rk(10), KZ_R10);

        // key held valid: accepted once per DONE visit; keys_valid is a
        // one-cycle pulse, and the rises are one expansion plus one DONE cycle apart
        @(negedge clk);
        key_in = K1;
        key_valid = 1'b1;
        prev = keys_valid;
        rises = 0;
        highs = 0;
        r1 = -1;
        r2 = -1;
        for (int n = 1; n <= 2 * LAT + 3; n++) begin
            @(posedge clk);
            #1;
            if (busy && keys_valid) overlap++;
            if (keys_valid) highs++;
            if (keys_valid && !prev) begin
                rises++;
                if (rises == 1) r1 = n;
                else            r2 = n;
            end
            prev = keys_valid;
        end
        key_valid = 1'b0;
        chk("hold_rises", rises, 2);
        chk("hold_pulse_width", highs, 2);
        chk("hold_first_rise", r1, LAT + 1);
        chk("hold_interval", r2 - r1, LAT + 1);
        chk("hold_rk10", rk(10), K1_R10);
        chk("kv_busy_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
